// File: rtl/rect_box_tracker.sv
// rect_box_tracker
// Per-frame bounding-box tracker feeding the rectangle overlay stage.
// Accumulates min/max coordinates and a hit count of classified pixels
// during active video, then on each frame end commits a clamped box with
// miss hysteresis. A parked all-zero box is output when nothing is tracked.
module rect_box_tracker #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned RECT_WIDTH  = 5,
    parameter int unsigned MIN_PIXELS  = 64,
    parameter int unsigned MISS_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pix_valid,
    input  logic        skin_hit,
    input  logic        frame_end,
    output logic [9:0]  left,
    output logic [9:0]  right,
    output logic [9:0]  top,
    output logic [9:0]  bottom,
    output logic        box_valid,
    output logic        frame_done,
    output logic [18:0] hit_count
);

    localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
    localparam logic [9:0]  MARGIN   = 10'(RECT_WIDTH);
    localparam logic [9:0]  R_MAX    = 10'(H_ACTIVE - 1 - RECT_WIDTH);
    localparam logic [9:0]  B_MAX    = 10'(V_ACTIVE - 1 - RECT_WIDTH);
    localparam logic [18:0] MIN_CNT  = 19'(MIN_PIXELS);
    localparam logic [4:0]  MISS_LIM = 5'(MISS_FRAMES);

    typedef enum logic {
        ACCUM  = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        commit;
    logic        pixel_hit;

    logic [9:0]  min_x;
    logic [9:0]  max_x;
    logic [9:0]  min_y;
    logic [9:0]  max_y;
    logic [18:0] cnt;
    logic [3:0]  miss_cnt;
    logic [4:0]  miss_next;

    logic [9:0]  clamp_l;
    logic [9:0]  clamp_r;
    logic [9:0]  clamp_t;
    logic [9:0]  clamp_b;
    logic        frame_hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; a hit on the frame_end cycle is dropped.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        pixel_hit  = 1'b0;
        case (state)
            ACCUM: begin
                if (frame_end) begin
                    state_next = COMMIT;
                end else begin
                    pixel_hit = pix_valid && skin_hit &&
                                (pixel_x < H_LIM) && (pixel_y < V_LIM);
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = ACCUM;
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Per-frame min/max and saturating hit-count accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
            cnt   <= '0;
        end else if (commit) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
            cnt   <= '0;
        end else if (pixel_hit) begin
            if (pixel_x < min_x) min_x <= pixel_x;
            if (pixel_x > max_x) max_x <= pixel_x;
            if (pixel_y < min_y) min_y <= pixel_y;
            if (pixel_y > max_y) max_y <= pixel_y;
            if (cnt != '1) cnt <= cnt + 19'd1;
        end
    end

    // Clamp keeps edge +/- border width inside 10 bits; an empty frame
    // leaves min > max, so it can never pass the ordering test.
    always_comb begin
        clamp_l   = (min_x < MARGIN) ? MARGIN : min_x;
        clamp_r   = (max_x > R_MAX)  ? R_MAX  : max_x;
        clamp_t   = (min_y < MARGIN) ? MARGIN : min_y;
        clamp_b   = (max_y > B_MAX)  ? B_MAX  : max_y;
        frame_hit = (cnt >= MIN_CNT) && (clamp_l <= clamp_r) && (clamp_t <= clamp_b);
        miss_next = {1'b0, miss_cnt} + 5'd1;
    end

    // Commit registers: outputs only move on the commit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left       <= '0;
            right      <= '0;
            top        <= '0;
            bottom     <= '0;
            box_valid  <= 1'b0;
            frame_done <= 1'b0;
            hit_count  <= '0;
            miss_cnt   <= '0;
        end else begin
            frame_done <= commit;
            if (commit) begin
                hit_count <= cnt;
                if (frame_hit) begin
                    left      <= clamp_l;
                    right     <= clamp_r;
                    top       <= clamp_t;
                    bottom    <= clamp_b;
                    box_valid <= 1'b1;
                    miss_cnt  <= '0;
                end else if (miss_next < MISS_LIM) begin
                    miss_cnt  <= miss_next[3:0];
                end else begin
                    left      <= '0;
                    right     <= '0;
                    top       <= '0;
                    bottom    <= '0;
                    box_valid <= 1'b0;
                    miss_cnt  <= MISS_LIM[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rect_box_tracker.sv
// Testbench for rect_box_tracker: directed scenarios plus randomized frames
// checked against a queue-based reference model of the box rules.
module tb_rect_box_tracker;

    localparam int HA    = 640;
    localparam int VA    = 480;
    localparam int RW    = 5;
    localparam int MINP  = 4;
    localparam int MISSF = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        pix_valid = 1'b0;
    logic        skin_hit = 1'b0;
    logic        frame_end = 1'b0;
    logic [9:0]  left;
    logic [9:0]  right;
    logic [9:0]  top;
    logic [9:0]  bottom;
    logic        box_valid;
    logic        frame_done;
    logic [18:0] hit_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          qx[$];
    int          qy[$];
    logic [9:0]  m_l, m_r, m_t, m_b;
    logic        m_v;
    logic [18:0] m_hc;
    int          m_miss;

    rect_box_tracker #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .RECT_WIDTH(RW),
        .MIN_PIXELS(MINP),
        .MISS_FRAMES(MISSF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .pix_valid(pix_valid),
        .skin_hit(skin_hit),
        .frame_end(frame_end),
        .left(left),
        .right(right),
        .top(top),
        .bottom(bottom),
        .box_valid(box_valid),
        .frame_done(frame_done),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [59:0] got_vec();
        return {left, right, top, bottom, box_valid, hit_count};
    endfunction

    function automatic logic [59:0] exp_vec();
        return {m_l, m_r, m_t, m_b, m_v, m_hc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0;
        skin_hit  = 1'b0;
        frame_end = 1'b0;
        pixel_x   = '0;
        pixel_y   = '0;
    endtask

    task automatic model_reset();
        qx.delete();
        qy.delete();
        m_l = '0; m_r = '0; m_t = '0; m_b = '0;
        m_v = 1'b0; m_hc = '0; m_miss = 0;
    endtask

    // Evaluates the frame collected so far exactly as the box rules state.
    task automatic model_commit();
        int mnx, mxx, mny, mxy, n, bl, br, bt, bb;
        bit hit;
        mnx = 1023; mxx = 0; mny = 1023; mxy = 0;
        n = qx.size();
        foreach (qx[i]) begin
            if (qx[i] < mnx) mnx = qx[i];
            if (qx[i] > mxx) mxx = qx[i];
            if (qy[i] < mny) mny = qy[i];
            if (qy[i] > mxy) mxy = qy[i];
        end
        bl = (mnx > RW) ? mnx : RW;
        br = (mxx < HA - 1 - RW) ? mxx : HA - 1 - RW;
        bt = (mny > RW) ? mny : RW;
        bb = (mxy < VA - 1 - RW) ? mxy : VA - 1 - RW;
        hit = (n >= MINP) && (bl <= br) && (bt <= bb);
        m_hc = 19'(n);
        if (hit) begin
            m_l = 10'(bl); m_r = 10'(br); m_t = 10'(bt); m_b = 10'(bb);
            m_v = 1'b1;
            m_miss = 0;
        end else if (m_miss + 1 < MISSF) begin
            m_miss++;
        end else begin
            m_l = '0; m_r = '0; m_t = '0; m_b = '0;
            m_v = 1'b0;
            m_miss = MISSF;
        end
        qx.delete();
        qy.delete();
    endtask

    task automatic send_pixel(input int x, input int y, input logic v, input logic h);
        pixel_x   = 10'(x);
        pixel_y   = 10'(y);
        pix_valid = v;
        skin_hit  = h;
        tick();
        if (v && h && x < HA && y < VA) begin
            qx.push_back(x);
            qy.push_back(y);
        end
        idle_inputs();
    endtask

    // Drives frame_end (optionally with a hit on the same cycle) and returns
    // on the cycle where the commit is visible.
    task automatic end_frame(input logic fe_hit, input int x, input int y);
        pixel_x   = 10'(x);
        pixel_y   = 10'(y);
        pix_valid = fe_hit;
        skin_hit  = fe_hit;
        frame_end = 1'b1;
        tick();
        idle_inputs();
        model_commit();
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (got_vec() !== 60'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h done=%b, want 0 done=0", got_vec(), frame_done);
        end
        rst = 1'b0;
        tick();
        end_frame(1'b0, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_empty_frame: got %h done=%b, want %h done=1", got_vec(), frame_done, exp_vec());
        end
    endtask

    task automatic test_basic_box();
        logic [59:0] prev;
        send_pixel(100, 50, 1'b1, 1'b1);
        send_pixel(300, 50, 1'b1, 1'b1);
        send_pixel(100, 200, 1'b1, 1'b1);
        send_pixel(300, 200, 1'b1, 1'b1);
        prev = exp_vec();
        frame_end = 1'b1;
        tick();
        idle_inputs();
        model_commit();
        n_checks++;
        if (frame_done !== 1'b0 || got_vec() !== prev) begin
            n_fail++;
            $display("FAIL basic_commit_cycle: got %h done=%b, want %h done=0", got_vec(), frame_done, prev);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL basic_box: got %h done=%b, want %h done=1", got_vec(), frame_done, exp_vec());
        end
        n_checks++;
        if ({left, right, top, bottom, box_valid, hit_count} !== {10'd100, 10'd300, 10'd50, 10'd200, 1'b1, 19'd4}) begin
            n_fail++;
            $display("FAIL basic_const: got l=%0d r=%0d t=%0d b=%0d v=%b hc=%0d, want 100 300 50 200 1 4",
                     left, right, top, bottom, box_valid, hit_count);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %h done=%b, want %h done=0", got_vec(), frame_done, exp_vec());
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 4; i++) send_pixel(0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_pixel(639, 479, 1'b1, 1'b1);
        end_frame(1'b0, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL clamp_model: got %h, want %h", got_vec(), exp_vec());
        end
        n_checks++;
        if ({left, right, top, bottom, hit_count} !== {10'd5, 10'd634, 10'd5, 10'd474, 19'd8}) begin
            n_fail++;
            $display("FAIL clamp_const: got l=%0d r=%0d t=%0d b=%0d hc=%0d, want 5 634 5 474 8",
                     left, right, top, bottom, hit_count);
        end
    endtask

    task automatic test_miss_hysteresis();
        for (int k = 1; k <= 3; k++) begin
            send_pixel(200, 200, 1'b1, 1'b1);
            send_pixel(210, 210, 1'b1, 1'b1);
            send_pixel(220, 220, 1'b1, 1'b1);
            end_frame(1'b0, 0, 0);
            n_checks++;
            if (frame_done !== 1'b1 || got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL miss_%0d_model: got %h, want %h", k, got_vec(), exp_vec());
            end
            n_checks++;
            if (k < 3 && {left, right, box_valid} !== {10'd5, 10'd634, 1'b1}) begin
                n_fail++;
                $display("FAIL miss_%0d_held: got l=%0d r=%0d v=%b, want 5 634 1", k, left, right, box_valid);
            end else if (k == 3 && {left, right, top, bottom, box_valid} !== 41'd0) begin
                n_fail++;
                $display("FAIL miss_3_parked: got l=%0d r=%0d t=%0d b=%0d v=%b, want all 0",
                         left, right, top, bottom, box_valid);
            end
        end
    endtask

    task automatic test_frame_end_hit();
        send_pixel(10, 10, 1'b1, 1'b1);
        send_pixel(20, 20, 1'b1, 1'b1);
        send_pixel(15, 12, 1'b1, 1'b1);
        send_pixel(12, 18, 1'b1, 1'b1);
        end_frame(1'b1, 600, 400);
        n_checks++;
        if (got_vec() !== exp_vec() ||
            {left, right, top, bottom, box_valid, hit_count} !== {10'd10, 10'd20, 10'd10, 10'd20, 1'b1, 19'd4}) begin
            n_fail++;
            $display("FAIL frame_end_hit: got l=%0d r=%0d t=%0d b=%0d v=%b hc=%0d, want 10 20 10 20 1 4",
                     left, right, top, bottom, box_valid, hit_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 100; i++)
            send_pixel($urandom_range(0, HA - 1), $urandom_range(0, VA - 1), 1'b1, 1'b1);
        rst = 1'b1;
        #2;
        n_checks++;
        if (got_vec() !== 60'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %h done=%b, want 0 done=0", got_vec(), frame_done);
        end
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) send_pixel(50, 60, 1'b1, 1'b1);
        end_frame(1'b0, 0, 0);
        n_checks++;
        if (got_vec() !== exp_vec() ||
            {left, right, top, bottom, box_valid, hit_count} !== {10'd50, 10'd50, 10'd60, 10'd60, 1'b1, 19'd4}) begin
            n_fail++;
            $display("FAIL rst_mid_frame: got l=%0d r=%0d t=%0d b=%0d v=%b hc=%0d, want 50 50 60 60 1 4",
                     left, right, top, bottom, box_valid, hit_count);
        end
    endtask

    task automatic test_ignored();
        send_pixel(100, 100, 1'b0, 1'b1);
        send_pixel(700, 100, 1'b1, 1'b1);
        send_pixel(100, 500, 1'b1, 1'b1);
        send_pixel(100, 100, 1'b1, 1'b0);
        end_frame(1'b0, 0, 0);
        n_checks++;
        if (got_vec() !== exp_vec() || hit_count !== 19'd0 || box_valid !== 1'b1 || left !== 10'd50) begin
            n_fail++;
            $display("FAIL ignored_pixels: got %h, want %h (hc 0, box held)", got_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        send_pixel(30, 40, 1'b1, 1'b1);
        send_pixel(60, 80, 1'b1, 1'b1);
        send_pixel(31, 41, 1'b1, 1'b1);
        send_pixel(59, 79, 1'b1, 1'b1);
        end_frame(1'b0, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_first: got %h, want %h", got_vec(), exp_vec());
        end
        end_frame(1'b0, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || got_vec() !== exp_vec() || hit_count !== 19'd0 || left !== 10'd30) begin
            n_fail++;
            $display("FAIL b2b_empty: got %h done=%b, want %h done=1", got_vec(), frame_done, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            int n;
            int mode;
            n = $urandom_range(0, 9);
            mode = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                int x, y;
                if (mode == 0) begin
                    x = $urandom_range(0, 10);
                    y = $urandom_range(0, 10);
                end else begin
                    x = $urandom_range(0, 700);
                    y = $urandom_range(0, 520);
                end
                send_pixel(x, y, logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 7) != 0));
            end
            end_frame(logic'($urandom_range(0, 1)), $urandom_range(0, 639), $urandom_range(0, 479));
            n_checks++;
            if (frame_done !== 1'b1 || got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_frame_%0d: got %h done=%b, want %h done=1", f, got_vec(), frame_done, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_box();
        test_clamp();
        test_miss_hysteresis();
        test_frame_end_hit();
        test_reset_mid_frame();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
